// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and sync boundary helper
// shared by the VGA timing generator and its axis counters.
package vga_timing_pkg;

    localparam int DEF_CNT_W    = 10;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        int lo;
        int hi;
    } sync_bounds_t;

    function automatic sync_bounds_t sync_bounds(
        input int active,
        input int fp,
        input int width
    );
        sync_bounds_t b;
        b.lo = active + fp;
        b.hi = active + fp + width - 1;
        return b;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel enable in, raster counts and sync/flag outputs back.
// frameCount is present only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if #(
    parameter int CNT_W = vga_timing_pkg::DEF_CNT_W
);
    logic             pixEn;
    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             hSync;
    logic             vSync;
    logic             videoOn;
    logic             lineEnd;
    logic             frameEnd;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]       frameCount;
`endif

    modport master (
        input  pixEn,
        output hCount,
        output vCount,
        output hSync,
        output vSync,
        output videoOn,
        output lineEnd,
`ifdef VGA_FRAME_CNT_EN
        output frameCount,
`endif
        output frameEnd
    );

    modport slave (
        output pixEn,
        input  hCount,
        input  vCount,
        input  hSync,
        input  vSync,
        input  videoOn,
        input  lineEnd,
`ifdef VGA_FRAME_CNT_EN
        input  frameCount,
`endif
        input  frameEnd
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with registered sync, plus
// next-state last/active decodes so the parent can register them.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             last_next,
    output logic             active_next
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam sync_bounds_t SB = sync_bounds(ACTIVE, FP, SYNC);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SB.lo);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SB.hi);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 ||
        TOTAL > (1 << CNT_W)) begin : g_bad_params
        $error("vga_axis_counter: zero interval or total exceeds CNT_W");
    end

    logic [CNT_W-1:0] count_next;
    logic             sync_next;

    always_comb begin
        count_next = count;
        if (step) begin
            count_next = (count == LAST) ? '0 : count + CNT_W'(1);
        end
        sync_next   = (count_next >= SYNC_LO && count_next <= SYNC_HI)
                    ? POL : ~POL;
        last_next   = (count_next == LAST);
        active_next = (count_next < ACT_END);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            sync  <= sync_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two axis counters, all outputs registered.
// Define VGA_FRAME_CNT_EN to add the 8-bit frameCount output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic         Clk,
    input  logic         vgaRes,
    vga_timing_if.master bus
);

    logic h_last_n;
    logic h_act_n;
    logic v_last_n;
    logic v_act_n;
    logic v_step;

    // lineEnd is the registered hCount==H_TOTAL-1, i.e. the wrap cycle.
    assign v_step = bus.pixEn & bus.lineEnd;

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (HS_POL)
    ) u_h (
        .clk        (Clk),
        .rst_n      (vgaRes),
        .step       (bus.pixEn),
        .count      (bus.hCount),
        .sync       (bus.hSync),
        .last_next  (h_last_n),
        .active_next(h_act_n)
    );

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (VS_POL)
    ) u_v (
        .clk        (Clk),
        .rst_n      (vgaRes),
        .step       (v_step),
        .count      (bus.vCount),
        .sync       (bus.vSync),
        .last_next  (v_last_n),
        .active_next(v_act_n)
    );

    always_ff @(posedge Clk) begin
        if (!vgaRes) begin
            bus.videoOn  <= 1'b1;
            bus.lineEnd  <= 1'b0;
            bus.frameEnd <= 1'b0;
        end else begin
            bus.videoOn  <= h_act_n & v_act_n;
            bus.lineEnd  <= h_last_n;
            bus.frameEnd <= h_last_n & v_last_n;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge Clk) begin
        if (!vgaRes) begin
            bus.frameCount <= 8'd0;
        end else if (bus.pixEn && bus.frameEnd) begin
            bus.frameCount <= bus.frameCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 and a tiny 8x6 raster
// driven side by side against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        int h;
        int v;
        bit hs;
        bit vs;
        bit von;
        bit le;
        bit fe;
        int fc;
    } outs_t;

    typedef struct {
        bit rst;
        bit en;
        int n;
        int h;
        int v;
        bit hs;
        bit vs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_if #(.CNT_W(10)) bd();
    vga_timing_if #(.CNT_W(4))  bs();

    vga_timing_gen dut_d (
        .Clk   (clk),
        .vgaRes(rst_n),
        .bus   (bd)
    );

    vga_timing_gen #(
        .CNT_W(4),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .Clk   (clk),
        .vgaRes(rst_n),
        .bus   (bs)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int nd = 0;
    int ns = 0;

    function automatic outs_t model(
        input int n,
        input int ha, input int hf, input int hsw, input int hb,
        input int va, input int vf, input int vsw, input int vb,
        input bit hp, input bit vp
    );
        outs_t o;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        o.h   = n % ht;
        o.v   = (n / ht) % vt;
        o.hs  = (o.h >= ha + hf && o.h < ha + hf + hsw) ? hp : ~hp;
        o.vs  = (o.v >= va + vf && o.v < va + vf + vsw) ? vp : ~vp;
        o.von = (o.h < ha) && (o.v < va);
        o.le  = (o.h == ht - 1);
        o.fe  = o.le && (o.v == vt - 1);
`ifdef VGA_FRAME_CNT_EN
        o.fc  = (n / (ht * vt)) % 256;
`else
        o.fc  = 0;
`endif
        return o;
    endfunction

    task automatic cmp_outs(input string name, input outs_t a, input outs_t e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b von=%0b le=%0b fe=%0b fc=%0d want h=%0d v=%0d hs=%0b vs=%0b von=%0b le=%0b fe=%0b fc=%0d",
                    name, a.h, a.v, a.hs, a.vs, a.von, a.le, a.fe, a.fc,
                    e.h, e.v, e.hs, e.vs, e.von, e.le, e.fe, e.fc);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_both();
        outs_t a;
        a.h = int'(bd.hCount); a.v = int'(bd.vCount);
        a.hs = bd.hSync; a.vs = bd.vSync; a.von = bd.videoOn;
        a.le = bd.lineEnd; a.fe = bd.frameEnd;
`ifdef VGA_FRAME_CNT_EN
        a.fc = int'(bd.frameCount);
`else
        a.fc = 0;
`endif
        cmp_outs("dflt_cycle", a,
            model(nd, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        a.h = int'(bs.hCount); a.v = int'(bs.vCount);
        a.hs = bs.hSync; a.vs = bs.vSync; a.von = bs.videoOn;
        a.le = bs.lineEnd; a.fe = bs.frameEnd;
`ifdef VGA_FRAME_CNT_EN
        a.fc = int'(bs.frameCount);
`else
        a.fc = 0;
`endif
        cmp_outs("small_cycle", a,
            model(ns, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1));
    endtask

    task automatic cyc(input bit r, input bit ed, input bit es);
        @(negedge clk);
        rst_n    = r;
        bd.pixEn = ed;
        bs.pixEn = es;
        @(posedge clk);
        #1;
        if (!r) begin
            nd = 0;
            ns = 0;
        end else begin
            if (ed) nd++;
            if (es) ns++;
        end
        check_both();
    endtask

    vec_t vecs[$];

    initial begin
        int lo_cnt, lo_min, lo_max, le_cnt, first_off;
        int glitch, fe_cnt, vs_cnt, hs_cnt;
        bit prev_hs, prev_vs;

        rst_n    = 1'b0;
        bd.pixEn = 1'b0;
        bs.pixEn = 1'b0;

        // reset, then mid-line reset at hCount=300, then hold
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        for (int i = 0; i < 300; i++) cyc(1, 1, 1);
        chk("pre_rst_h", int'(bd.hCount), 300);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1);
            chk("rst_h", int'(bd.hCount), 0);
        end
        chk("rst_v", int'(bd.vCount), 0);
        chk("rst_hsync", int'(bd.hSync), 1);
        chk("rst_vsync", int'(bd.vSync), 1);
        chk("rst_von", int'(bd.videoOn), 1);
        chk("rst_le", int'(bd.lineEnd), 0);
        chk("rst_fe", int'(bd.frameEnd), 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        chk("hold_h", int'(bd.hCount), 0);
        chk("hold_hsync", int'(bd.hSync), 1);

        // two full default lines
        cyc(0, 1, 1);
        lo_cnt = 0; lo_min = 9999; lo_max = -1; le_cnt = 0; first_off = -1;
        for (int i = 0; i < 1600; i++) begin
            cyc(1, 1, 1);
            if (!bd.hSync) begin
                lo_cnt++;
                if (int'(bd.hCount) < lo_min) lo_min = int'(bd.hCount);
                if (int'(bd.hCount) > lo_max) lo_max = int'(bd.hCount);
            end
            if (bd.lineEnd) le_cnt++;
            if (!bd.videoOn && first_off < 0) first_off = int'(bd.hCount);
            if (i == 798) chk("line_end_h", int'(bd.hCount), 799);
            if (i == 799) begin
                chk("wrap_h", int'(bd.hCount), 0);
                chk("wrap_v", int'(bd.vCount), 1);
            end
        end
        chk("hs_low_cnt", lo_cnt, 192);
        chk("hs_low_min", lo_min, 656);
        chk("hs_low_max", lo_max, 751);
        chk("le_cnt", le_cnt, 2);
        chk("von_off_h", first_off, 640);
        chk("two_lines_v", int'(bd.vCount), 2);

        // enable gating: one step every two clocks
        cyc(0, 1, 1);
        glitch = 0;
        for (int i = 0; i < 1600; i++) begin
            prev_hs = bd.hSync;
            prev_vs = bs.vSync;
            cyc(1, (i % 2) == 0, (i % 2) == 0);
            if ((i % 2) == 1 && (bd.hSync != prev_hs || bs.vSync != prev_vs))
                glitch++;
        end
        chk("gate_h", int'(bd.hCount), 0);
        chk("gate_v", int'(bd.vCount), 1);
        chk("gate_glitch", glitch, 0);

        // one full small frame
        cyc(0, 1, 1);
        fe_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            cyc(1, 1, 1);
            if (bs.frameEnd) fe_cnt++;
            if (bs.vSync) vs_cnt++;
            if (bs.hSync) hs_cnt++;
        end
        chk("small_fe_cnt", fe_cnt, 1);
        chk("small_vs_cnt", vs_cnt, 8);
        chk("small_hs_cnt", hs_cnt, 12);
        chk("small_frame_h", int'(bs.hCount), 0);
        chk("small_frame_v", int'(bs.vCount), 0);

        // table of small-raster sequences
        vecs.push_back('{0, 1, 1,  0, 0, 0, 0});
        vecs.push_back('{1, 1, 5,  5, 0, 1, 0});
        vecs.push_back('{1, 0, 4,  5, 0, 1, 0});
        vecs.push_back('{1, 1, 2,  7, 0, 0, 0});
        vecs.push_back('{1, 1, 1,  0, 1, 0, 0});
        vecs.push_back('{1, 1, 24, 0, 4, 0, 1});
        vecs.push_back('{1, 1, 6,  6, 4, 1, 1});
        vecs.push_back('{1, 1, 10, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1,  0, 0, 0, 0});
        vecs.push_back('{1, 1, 13, 5, 1, 1, 0});
        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].n; i++)
                cyc(vecs[k].rst, vecs[k].en, vecs[k].en);
            chk($sformatf("vec%0d_h", k), int'(bs.hCount), vecs[k].h);
            chk($sformatf("vec%0d_v", k), int'(bs.vCount), vecs[k].v);
            chk($sformatf("vec%0d_hs", k), int'(bs.hSync), int'(vecs[k].hs));
            chk($sformatf("vec%0d_vs", k), int'(bs.vSync), int'(vecs[k].vs));
        end

`ifdef VGA_FRAME_CNT_EN
        cyc(0, 1, 1);
        chk("fc_rst", int'(bs.frameCount), 0);
        for (int f = 1; f <= 256; f++) begin
            for (int i = 0; i < 48; i++) cyc(1, 0, 1);
            if (f == 1)   chk("fc_first", int'(bs.frameCount), 1);
            if (f == 255) chk("fc_255", int'(bs.frameCount), 255);
            if (f == 256) chk("fc_wrap", int'(bs.frameCount), 0);
        end
`endif

        // randomized enables with rare resets
        cyc(0, 1, 1);
        for (int i = 0; i < 20000; i++)
            cyc($urandom_range(0, 999) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
